uart_tx_shifter: RTL and testbench
==================================

// Module: uart_tx_shifter
// PURPOSE
//  Serial datapath of the UART transmitter, directly downstream of the TX control FSM.
//  - Captures a byte on the FSM's one-cycle tx_start pulse.
//  - While tx_sel is held, emits the frame LSB-first on tx_out, paced by an internal baud divider.
//  - Frame order: start, data, optional parity, stop.
//  - Pulses tx_done so the FSM returns to IDLE.
// PARAMETERS
//  BAUD_DIV   5208  clk cycles per bit (50 MHz / 9600); legal range >= 1
//  DATA_BITS  8     data bits per frame; legal range 5..8
//  PARITY_EN  0     1 = append parity bit after data
//  PARITY_ODD 0     1 = odd parity, 0 = even parity; ignored if PARITY_EN=0
//  STOP_BITS  1     stop bits per frame; legal values 1 or 2
// PORTS
//  clk      in   1          single clock, rising edge
//  reset    in   1          asynchronous, active-low reset (asserted when 0)
//  tx_start in   1          one-cycle load strobe from TX FSM (LOAD state)
//  tx_sel   in   1          held high by TX FSM for the whole TRANSMIT state
//  tx_data  in   DATA_BITS  byte to send; sampled only on the tx_start cycle
//  tx_out   out  1          serial line; idles high
//  tx_done  out  1          one-cycle pulse at end of final stop bit
//  tx_busy  out  1          high from load until frame completes or aborts
// BEHAVIOUR
//  - Reset (async, reset==0): tx_out=1, tx_done=0, tx_busy=0, baud count=0, bit index=0, frame reg cleared.
//  - Frame length: NBITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS.
//    Frame cycles = NBITS*BAUD_DIV.
//  - Load: tx_start=1 while tx_busy=0 latches tx_data, computes parity, sets tx_busy next edge.
//    A tx_start arriving while tx_busy=1 is ignored; the frame in progress is unaffected.
//  - Shift: on the first cycle with tx_busy=1 and tx_sel=1, tx_out drives the start bit (0).
//    tx_out is registered and changes only at bit boundaries.
//  - Baud counter: counts 0..BAUD_DIV-1 only while tx_busy & tx_sel; it is not free-running.
//    At terminal count it advances the bit index and loads the next bit onto tx_out.
//    Each bit is held exactly BAUD_DIV cycles.
//  - Bit order: start(0), d[0]..d[DATA_BITS-1], parity if PARITY_EN, stop(1) x STOP_BITS.
//    Even parity: XOR of data bits. Odd parity: its inverse.
//  - Completion: on the terminal count of the last stop bit:
//    tx_done=1 for exactly one cycle; tx_busy=0 and tx_out=1 on the same edge.
//    bit index and baud count return to 0.
//  - Back-to-back frames:
//    FSM IDLE->LOAD->TRANSMIT yields at least 2 idle-high cycles between frames.
//    tx_start is accepted on the cycle after tx_done.
//  - Abort: tx_sel=0 while tx_busy=1 forces tx_out=1, tx_busy=0, counters=0 on the next edge.
//    No tx_done is issued on abort.
//  - tx_sel=1 with tx_busy=0: ignored; tx_out stays 1 and tx_done stays 0.
//  - Reset mid-frame: tx_out goes high asynchronously, all state clears, no tx_done.
//  - BAUD_DIV=1: every bit lasts one cycle; the counter degenerates to a constant terminal-count flag.
//  - Counter widths: baud counter $clog2(BAUD_DIV)+1 bits; bit index $clog2(NBITS)+1 bits.
//    No wrap occurs past terminal count.
// STRUCTURE
//  - Package uart_pkg holds:
//    default BAUD_DIV/DATA_BITS constants;
//    function frame_len(DATA_BITS,PARITY_EN,STOP_BITS);
//    localparam UART_IDLE_LEVEL=1'b1.
//  - Sub-module uart_baud_gen(clk, reset, en, tick):
//    counter clears when en=0; tick marks the terminal count.
//  - Top level holds the frame shift register, bit index, parity, and output/done registers.
// TESTING (BAUD_DIV=4 unless noted; checker samples tx_out mid-bit)
//  1. 8N1, tx_data=8'hA5:
//     tx_out=0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles.
//     tx_done pulses once, 40 cycles after the first tx_sel cycle; tx_busy then 0.
//  2. PARITY_EN=1, even parity:
//     8'hA5 gives parity bit 0. 8'h01 gives parity bit 1.
//     With PARITY_ODD=1, 8'h01 gives parity bit 0. Frame is 11 bits (44 cycles).
//  3. STOP_BITS=2, 8'hFF: two stop bits; tx_done at cycle 44.
//     A tx_start on the cycle after tx_done starts a new frame cleanly.
//  4. Abort: drop tx_sel at cycle 15 of a frame.
//     tx_out=1 on the next cycle, tx_busy=0, no tx_done; the next frame (8'h3C) is bit-exact.
//  5. Reset mid-frame: reset=0 at cycle 9 (asynchronous, between edges).
//     tx_out=1 immediately and all outputs at reset values; a new frame after release is correct.
//  6. Ignore stray strobes: tx_start with 8'h00 mid-frame leaves the frame unchanged.
//     tx_sel=1 with no load keeps tx_out=1 for 50 cycles.
//     BAUD_DIV=1 run of 8'h5A completes in 10 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit datapath.
// Holds default frame constants, the idle line level, the shifter state
// encoding, and helpers for frame length and parity.
package uart_pkg;

    localparam int   DEFAULT_BAUD_DIV  = 5208;
    localparam int   DEFAULT_DATA_BITS = 8;
    localparam logic UART_IDLE_LEVEL   = 1'b1;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_e;

    // Total bits on the line for one frame: start + data + parity + stops.
    function automatic int frame_len(input int data_bits, input int parity_en, input int stop_bits);
        return 32'sd1 + data_bits + parity_en + stop_bits;
    endfunction

    // Parity over a zero-extended data byte. Unused upper bits must be zero.
    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_shifter_if.sv
// Handshake bundle between the TX control FSM (master) and the serial
// shifter (slave).
//   tx_start : one-cycle load strobe, FSM -> shifter
//   tx_sel   : held high for the whole transmit phase, FSM -> shifter
//   tx_data  : byte to send, sampled on the tx_start cycle, FSM -> shifter
//   tx_out   : serial line, idles high, shifter -> line
//   tx_done  : one-cycle pulse at end of the final stop bit, shifter -> FSM
//   tx_busy  : high from load until the frame completes or aborts
interface uart_tx_shifter_if #(
    parameter int DATA_BITS = uart_pkg::DEFAULT_DATA_BITS
);
    logic                 tx_start;
    logic                 tx_sel;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_out;
    logic                 tx_done;
    logic                 tx_busy;

    modport master (
        output tx_start,
        output tx_sel,
        output tx_data,
        input  tx_out,
        input  tx_done,
        input  tx_busy
    );

    modport slave (
        input  tx_start,
        input  tx_sel,
        input  tx_data,
        output tx_out,
        output tx_done,
        output tx_busy
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter for the UART transmitter.
// Counts 0..BAUD_DIV-1 only while en is high and clears whenever en drops,
// so each bit period starts from a known phase.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   en    : count enable (busy and selected)
//   tick  : high on the terminal-count cycle while enabled
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int            CW   = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0] TERM = CW'(BAUD_DIV - 1);

    logic [CW-1:0] count_r;
    logic          tick_s;

    // With BAUD_DIV=1 the counter never leaves 0, so tick is simply en.
    assign tick_s = en & (count_r == TERM);
    assign tick   = tick_s;

    // Bit-period counter: clears when disabled and at terminal count, never wraps past it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (!en) begin
            count_r <= '0;
        end else if (tick_s) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_shifter.sv
// Serial datapath of the UART transmitter.
// Latches a byte on tx_start, then, while tx_sel is held, shifts the frame
// (start, data LSB-first, optional parity, stop bits) onto tx_out with each
// bit lasting BAUD_DIV cycles. Pulses tx_done after the last stop bit.
// Dropping tx_sel mid-frame aborts silently back to idle.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : slave side of uart_tx_shifter_if (tx_start, tx_sel, tx_data in;
//           tx_out, tx_done, tx_busy out, all registered)
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_shifter_if.slave    bus
);

    localparam int             NBITS = frame_len(DATA_BITS, PARITY_EN, STOP_BITS);
    localparam int             IDX_W = $clog2(NBITS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBITS - 1);

    tx_state_e          state_r;
    logic [NBITS-1:0]   frame_r;
    logic [IDX_W-1:0]   bit_idx_r;
    logic               tx_out_r;
    logic               tx_done_r;
    logic               tx_busy_r;

    logic [NBITS-1:0]   frame_s;
    logic               par_s;
    logic               baud_en_s;
    logic               tick_s;

    assign baud_en_s = tx_busy_r & bus.tx_sel;

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .en    (baud_en_s),
        .tick  (tick_s)
    );

    // Assemble the whole frame, LSB = first bit on the line.
    always_comb begin
        par_s   = parity_bit(8'(bus.tx_data), (PARITY_ODD != 0));
        frame_s = '1;
        frame_s[0] = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) begin
            frame_s[1 + i] = bus.tx_data[i];
        end
        // Without parity this position is the first stop bit.
        frame_s[1 + DATA_BITS] = (PARITY_EN != 0) ? par_s : 1'b1;
    end

    // Shifter state machine with registered line, done and busy outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= TX_IDLE;
            frame_r   <= '0;
            bit_idx_r <= '0;
            tx_out_r  <= UART_IDLE_LEVEL;
            tx_done_r <= 1'b0;
            tx_busy_r <= 1'b0;
        end else begin
            case (state_r)
                TX_IDLE: begin
                    tx_done_r <= 1'b0;
                    if (bus.tx_start) begin
                        // Start bit goes out immediately so it is on the line
                        // for the first selected cycle.
                        state_r   <= TX_SHIFT;
                        frame_r   <= frame_s;
                        bit_idx_r <= '0;
                        tx_out_r  <= frame_s[0];
                        tx_busy_r <= 1'b1;
                    end else begin
                        state_r   <= TX_IDLE;
                        tx_out_r  <= UART_IDLE_LEVEL;
                        tx_busy_r <= 1'b0;
                    end
                end
                TX_SHIFT: begin
                    if (!bus.tx_sel) begin
                        // Abort: return to idle without a done pulse.
                        state_r   <= TX_IDLE;
                        frame_r   <= '0;
                        bit_idx_r <= '0;
                        tx_out_r  <= UART_IDLE_LEVEL;
                        tx_done_r <= 1'b0;
                        tx_busy_r <= 1'b0;
                    end else if (tick_s) begin
                        if (bit_idx_r == LAST_IDX) begin
                            state_r   <= TX_IDLE;
                            frame_r   <= '0;
                            bit_idx_r <= '0;
                            tx_out_r  <= UART_IDLE_LEVEL;
                            tx_done_r <= 1'b1;
                            tx_busy_r <= 1'b0;
                        end else begin
                            frame_r   <= {1'b1, frame_r[NBITS-1:1]};
                            bit_idx_r <= bit_idx_r + IDX_W'(1);
                            tx_out_r  <= frame_r[1];
                            tx_done_r <= 1'b0;
                        end
                    end else begin
                        tx_done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= TX_IDLE;
                    frame_r   <= '0;
                    bit_idx_r <= '0;
                    tx_out_r  <= UART_IDLE_LEVEL;
                    tx_done_r <= 1'b0;
                    tx_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_out  = tx_out_r;
    assign bus.tx_done = tx_done_r;
    assign bus.tx_busy = tx_busy_r;

endmodule

// File: tb/tb_uart_tx_shifter.sv
// Self-checking bench for uart_tx_shifter. Several instances cover the frame
// formats of interest; each is driven separately and compared cycle by cycle
// against a frame built from the bit-order and parity rules.
module tb_uart_tx_shifter;

    localparam int NDUT = 6;
    //                         8N1 8E1 8O1 8N2 8N1/1 5O2/3
    localparam int BD [NDUT] = '{4,  4,  4,  4,  1,   3};
    localparam int DB [NDUT] = '{8,  8,  8,  8,  8,   5};
    localparam int PE [NDUT] = '{0,  1,  1,  0,  0,   1};
    localparam int PO [NDUT] = '{0,  0,  1,  0,  0,   1};
    localparam int SB [NDUT] = '{1,  1,  1,  2,  1,   2};

    logic            clk;
    logic            reset;
    logic [NDUT-1:0] st_v;
    logic [NDUT-1:0] sel_v;
    logic [7:0]      dat_v [NDUT];
    logic [NDUT-1:0] out_v;
    logic [NDUT-1:0] done_v;
    logic [NDUT-1:0] busy_v;

    int checks;
    int errors;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uart_tx_shifter_if #(.DATA_BITS(DB[g])) bus ();
        uart_tx_shifter #(
            .BAUD_DIV   (BD[g]),
            .DATA_BITS  (DB[g]),
            .PARITY_EN  (PE[g]),
            .PARITY_ODD (PO[g]),
            .STOP_BITS  (SB[g])
        ) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
        assign bus.tx_start = st_v[g];
        assign bus.tx_sel   = sel_v[g];
        assign bus.tx_data  = dat_v[g][DB[g]-1:0];
        assign out_v[g]     = bus.tx_out;
        assign done_v[g]    = bus.tx_done;
        assign busy_v[g]    = bus.tx_busy;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, expv, $time);
        end
    endtask

    // Reference frame: start 0, data LSB first, parity from a count of ones, stop 1s.
    function automatic int build(input int k, input logic [7:0] d, output logic [15:0] bits);
        int n;
        int ones;
        bits = '1;
        n    = 0;
        ones = 0;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < DB[k]; i++) begin
            bits[n] = d[i];
            ones += int'(d[i]);
            n++;
        end
        if (PE[k] != 0) begin
            bits[n] = ((ones % 2) == 1) ^ (PO[k] != 0);
            n++;
        end
        n += SB[k];
        return n;
    endfunction

    // Entered just after a rising edge; returns just after the edge that
    // follows the completion (or would-be completion) cycle.
    task automatic run_frame(input int k, input logic [7:0] d, input int ab, input int stray);
        logic [15:0] bits;
        int nb;
        int f;
        logic eo, eb, ed;
        nb = build(k, d, bits);
        f  = nb * BD[k];
        st_v[k]  = 1'b1;
        dat_v[k] = d;
        @(negedge clk);
        chk($sformatf("load_out k%0d", k), out_v[k], 1'b1);
        chk($sformatf("load_busy k%0d", k), busy_v[k], 1'b0);
        chk($sformatf("load_done k%0d", k), done_v[k], 1'b0);
        @(posedge clk); #1;
        st_v[k]  = 1'b0;
        dat_v[k] = 8'($urandom);
        for (int c = 0; c <= f; c++) begin
            sel_v[k] = !(ab >= 0 && c >= ab);
            st_v[k]  = (c == stray);
            if (c == stray) dat_v[k] = 8'h00;
            if (ab >= 0 && c > ab) begin
                eo = 1'b1; eb = 1'b0; ed = 1'b0;
            end else if (c < f) begin
                eo = bits[c / BD[k]]; eb = 1'b1; ed = 1'b0;
            end else begin
                eo = 1'b1; eb = 1'b0; ed = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("out k%0d d%02h c%0d", k, d, c), out_v[k], eo);
            chk($sformatf("busy k%0d d%02h c%0d", k, d, c), busy_v[k], eb);
            chk($sformatf("done k%0d d%02h c%0d", k, d, c), done_v[k], ed);
            @(posedge clk); #1;
        end
        sel_v[k] = 1'b0;
        st_v[k]  = 1'b0;
    endtask

    initial begin
        logic [15:0] rbits;
        int rn;
        int k;
        int mode;
        int f;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        st_v   = '0;
        sel_v  = '0;
        for (int i = 0; i < NDUT; i++) dat_v[i] = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("rst_out k%0d", i), out_v[i], 1'b1);
            chk($sformatf("rst_busy k%0d", i), busy_v[i], 1'b0);
            chk($sformatf("rst_done k%0d", i), done_v[i], 1'b0);
        end
        reset = 1'b1;
        @(posedge clk); #1;

        // 8N1 A5, parity variants
        run_frame(0, 8'hA5, -1, -1);
        run_frame(1, 8'hA5, -1, -1);
        run_frame(1, 8'h01, -1, -1);
        run_frame(2, 8'h01, -1, -1);

        // Two stop bits, then a frame loaded on the cycle after tx_done
        run_frame(3, 8'hFF, -1, -1);
        run_frame(3, 8'h6E, -1, -1);

        // Abort at cycle 15, then a clean frame
        run_frame(0, 8'hC7, 15, -1);
        run_frame(0, 8'h3C, -1, -1);

        // Stray load strobe mid-frame
        run_frame(0, 8'h99, -1, 10);

        // tx_sel without a load keeps the line idle
        sel_v[0] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk($sformatf("idlesel_out c%0d", c), out_v[0], 1'b1);
            chk($sformatf("idlesel_done c%0d", c), done_v[0], 1'b0);
            @(posedge clk); #1;
        end
        sel_v[0] = 1'b0;

        // One cycle per bit
        run_frame(4, 8'h5A, -1, -1);

        // Asynchronous reset at cycle 9 of a frame
        rn = build(0, 8'hC3, rbits);
        st_v[0]  = 1'b1;
        dat_v[0] = 8'hC3;
        @(posedge clk); #1;
        st_v[0]  = 1'b0;
        sel_v[0] = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk($sformatf("prerst_out c%0d", c), out_v[0], rbits[c / BD[0]]);
            @(posedge clk); #1;
        end
        #2 reset = 1'b0;
        #1;
        chk("asyncrst_out", out_v[0], 1'b1);
        chk("asyncrst_busy", busy_v[0], 1'b0);
        chk("asyncrst_done", done_v[0], 1'b0);
        sel_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("heldrst_out", out_v[0], 1'b1);
        chk("heldrst_done", done_v[0], 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        run_frame(0, 8'h96, -1, -1);

        // Randomized frames on random formats
        for (int n = 0; n < 24; n++) begin
            k    = int'($urandom_range(0, NDUT - 1));
            mode = int'($urandom_range(0, 2));
            rn   = build(k, 8'h00, rbits);
            f    = rn * BD[k];
            if (mode == 1) begin
                run_frame(k, 8'($urandom), int'($urandom_range(0, f - 1)), -1);
            end else if (mode == 2) begin
                run_frame(k, 8'($urandom), -1, int'($urandom_range(0, f - 1)));
            end else begin
                run_frame(k, 8'($urandom), -1, -1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
